lcd_update_arbiter: RTL and testbench
=====================================

Name: lcd_update_arbiter

Overview:
- Shares the single LCD display writer between up to N requesters: reaction result, best-time tracker, status/attract message.
- Round-robin selects one pending request and latches its message code and 10-bit time.
- Drives the display's update/ack 4-phase handshake, then returns a one-cycle done pulse to the winning requester.
- Sits between the ReactionTimer-style producers and LCDDisplay; enforces a minimum gap between display rewrites and a watchdog on a stalled display.

Parameters:
- N, 3, number of requesters (2..8).
- HOLDOFF, 250, idle cycles enforced after each completed update before the next grant.
- TIMEOUT, 4095, cycles to wait for each ack edge before aborting; 12-bit counter.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  reset; one clock; reset is asynchronous and active-low.
- Req  in  N  per-requester level request; held until matching Done.
- ReqMsg  in  2*N  per-requester message code, slice i = [2i+1:2i]: 00 time, 01 cheat, 10 slow, 11 wait.
- ReqTime  in  10*N  per-requester reaction time in ms, slice i = [10i+9:10i].
- Done  out  N  one-cycle pulse to the served requester.
- Busy  out  1  high in any state except IDLE.
- LCDUpdate  out  1  update request to the display.
- LCDAck  in  1  display acknowledge.
- Cheat, Slow, Wait  out  1 each  one-hot message flags to the display; all 0 for code 00.
- ReactionTime  out  10  time value to the display.
- Err  out  1  sticky flag, set on timeout.

Behaviour:
- Reset (Rst=0, asynchronous): state IDLE, round-robin pointer=N-1 (so requester 0 wins first), all outputs 0, counters 0.
- IDLE:
  - If any Req bit is high, pick the first set bit after the pointer, searching upward and wrapping.
  - Register its ReqMsg/ReqTime into the output flags and ReactionTime, update the pointer to the winner, then go to ASSERT.
  - Grant latency: 1 cycle from Req high to registered data.
- ASSERT:
  - LCDUpdate=1; data outputs stay stable until HOLD.
  - When LCDAck=1, LCDUpdate=0 on the next cycle and go to RELEASE.
- RELEASE:
  - Wait for LCDAck=0, then go to DONE.
- DONE:
  - Done[winner]=1 for exactly one cycle, then go to HOLD.
- HOLD:
  - Count HOLDOFF cycles, then return to IDLE. Req is ignored while counting.
  - HOLDOFF=0 means return to IDLE directly.
- Timeout:
  - In ASSERT or RELEASE, a counter restarts on state entry.
  - Reaching TIMEOUT sets Err=1, drops LCDUpdate, skips Done and goes to HOLD.
  - Err clears only on reset.
  - The pointer still advances, so a dead display cannot starve the other requesters.
- Req sampling:
  - Req and data are sampled only in IDLE.
  - A Req still high after its Done is served again in a later round-robin turn.
  - A Req dropped before grant is simply not served.
  - Req changes during ASSERT..HOLD have no effect.
- Simultaneous requests: strict round-robin. With all requesters high, grants go 0,1,2,0,... after reset.
- LCDAck already high on entry to ASSERT: treated as ack; go to RELEASE the next cycle.
- Busy is combinational from state.
- Flags:
  - Exactly one of Cheat/Slow/Wait is high for codes 01/10/11.
  - The flags hold their last value in IDLE; the display must only read them qualified by LCDUpdate.

Optional Feature:
- Macro LCD_ACK_SYNC_EN.
- Defined: LCDAck passes through a 2-flop synchronizer (reset to 0) before use, because the display runs on ClkLCD. Ack-to-state latency is +2 cycles, and the timeout counts from state entry as before.
- Undefined: LCDAck is used directly and must be synchronous to Clk.

Test Plan:
- Reset then Req=001, ReqMsg0=00, ReqTime0=10'd347; display model acks 3 cycles after LCDUpdate:
  - ReactionTime=347 and flags 000 while LCDUpdate is high.
  - LCDUpdate drops 1 cycle after ack.
  - Done=001 for one cycle after ack falls.
  - Busy low HOLDOFF cycles later.
- Req=111 held continuously, each slice a distinct code and time: served order 0,1,2,0,1,2; each LCDUpdate carries the matching slice's flags and time; no two updates within HOLDOFF cycles.
- Req1 high, ReqMsg1=01 (cheat): Cheat=1, Slow=0, Wait=0, Done=010; a second pass with code 11 gives Wait=1 only.
- Display never acks, Req=001: after TIMEOUT cycles Err=1, LCDUpdate=0, no Done pulse; then Req=010 is granted normally and Err stays 1.
- Assert Rst=0 mid-ASSERT: LCDUpdate, Busy and Done drop immediately without a clock edge; after release, Req=100 is still granted requester 0 first only if Req0 is set, otherwise requester 2.
- With LCD_ACK_SYNC_EN defined: same as the first scenario with LCDUpdate dropping 3 cycles after the raw ack; an ack pulse shorter than 1 cycle is covered as a negative check, so the model must hold ack for at least 2 Clk cycles.

Source files
------------

// File: rtl/lcd_update_arbiter.sv
// lcd_update_arbiter: round-robin arbiter sharing one LCD writer between N
// requesters. It latches the winner's message code and time, runs the
// update/ack 4-phase handshake, and pulses Done to the winner. After every
// update it enforces a hold-off gap, and a watchdog aborts a stalled handshake.
// Optional macro LCD_ACK_SYNC_EN: pass LCDAck through a 2-flop synchronizer
// when the display runs on its own clock.
module lcd_update_arbiter #(
    parameter int N       = 3,
    parameter int HOLDOFF = 250,
    parameter int TIMEOUT = 4095
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N-1:0]      i_req,
    input  logic [2*N-1:0]    i_req_msg,
    input  logic [10*N-1:0]   i_req_time,
    output logic [N-1:0]      o_done,
    output logic              o_busy,
    output logic              o_lcd_update,
    input  logic              i_lcd_ack,
    output logic              o_cheat,
    output logic              o_slow,
    output logic              o_wait,
    output logic [9:0]        o_reaction_time,
    output logic              o_err,
    output logic [2:0]        o_state
);

    localparam int PW = $clog2(N);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ASSERT  = 3'd1;
    localparam logic [2:0] S_RELEASE = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;

    // With no hold-off gap, finished or aborted updates go straight back to IDLE.
    localparam logic [2:0]  S_AFTER   = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
    localparam logic [11:0] C_TO_LAST = 12'(TIMEOUT - 1);
    localparam logic [11:0] C_HO_LAST = 12'(HOLDOFF - 1);

    // Handshake contract: LCDUpdate rises with stable data, stays high until
    // LCDAck is seen high, then the arbiter waits for LCDAck low before Done.

    logic [2:0]    r_state;
    logic [PW-1:0] r_ptr;
    logic [11:0]   r_cnt;
    logic [N-1:0]  r_done;
    logic          r_lcd_update;
    logic          r_cheat;
    logic          r_slow;
    logic          r_wait;
    logic [9:0]    r_time;
    logic          r_err;

    logic          w_ack;
    logic          w_found;
    logic [PW-1:0] w_win;
    logic [PW-1:0] w_cand;
    logic [1:0]    w_msg;
    logic [9:0]    w_time;
    logic [N-1:0]  w_done_vec;

`ifdef LCD_ACK_SYNC_EN
    logic r_ack_meta;
    logic r_ack_sync;

    // Two-flop synchronizer for the ack coming from the display clock domain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ack_meta <= 1'b0;
            r_ack_sync <= 1'b0;
        end else begin
            r_ack_meta <= i_lcd_ack;
            r_ack_sync <= r_ack_meta;
        end
    end

    assign w_ack = r_ack_sync;
`else
    assign w_ack = i_lcd_ack;
`endif

    // Round-robin search: first set request after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = r_ptr;
        for (int k = 0; k < N; k++) begin
            w_cand = (w_cand == PW'(N - 1)) ? '0 : w_cand + 1'b1;
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // Select the winner's message code and time slice.
    always_comb begin
        w_msg  = '0;
        w_time = '0;
        for (int i = 0; i < N; i++) begin
            if (w_win == PW'(i)) begin
                w_msg  = i_req_msg[2*i +: 2];
                w_time = i_req_time[10*i +: 10];
            end
        end
    end

    assign w_done_vec = {{(N-1){1'b0}}, 1'b1} << r_ptr;

    // Main arbiter FSM: grant, handshake, done pulse, hold-off, watchdog.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_ptr        <= PW'(N - 1);
            r_cnt        <= '0;
            r_done       <= '0;
            r_lcd_update <= 1'b0;
            r_cheat      <= 1'b0;
            r_slow       <= 1'b0;
            r_wait       <= 1'b0;
            r_time       <= '0;
            r_err        <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_ptr        <= w_win;
                        r_cheat      <= (w_msg == 2'b01);
                        r_slow       <= (w_msg == 2'b10);
                        r_wait       <= (w_msg == 2'b11);
                        r_time       <= w_time;
                        r_lcd_update <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= S_ASSERT;
                    end
                end
                S_ASSERT: begin
                    if (w_ack) begin
                        r_lcd_update <= 1'b0;
                        r_cnt        <= '0;
                        r_state      <= S_RELEASE;
                    end else if (r_cnt == C_TO_LAST) begin
                        r_lcd_update <= 1'b0;
                        r_err        <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= S_AFTER;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!w_ack) begin
                        r_done  <= w_done_vec;
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else if (r_cnt == C_TO_LAST) begin
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_AFTER;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_cnt   <= '0;
                    r_state <= S_AFTER;
                end
                S_HOLD: begin
                    if (r_cnt == C_HO_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_done          = r_done;
    assign o_busy          = (r_state != S_IDLE);
    assign o_lcd_update    = r_lcd_update;
    assign o_cheat         = r_cheat;
    assign o_slow          = r_slow;
    assign o_wait          = r_wait;
    assign o_reaction_time = r_time;
    assign o_err           = r_err;
    assign o_state         = r_state;

endmodule

// File: tb/tb_lcd_update_arbiter.sv
// Bench for lcd_update_arbiter: display model, scoreboard on LCD updates,
// table-driven grant vectors and hand-written handshake/timeout/reset sequences.
module tb_lcd_update_arbiter;

  localparam int N       = 3;
  localparam int HOLDOFF = 250;
  localparam int TIMEOUT = 4095;
  localparam int ACK_DLY = 3;
`ifdef LCD_ACK_SYNC_EN
  localparam int ACK_LAT = 2;
`else
  localparam int ACK_LAT = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic [2:0]    req;
  logic [5:0]    req_msg;
  logic [29:0]   req_time;
  logic [2:0]    done;
  logic          busy;
  logic          upd;
  logic          ack;
  logic          cheat;
  logic          slow;
  logic          wait_f;
  logic [9:0]    rtime;
  logic          err;
  logic [2:0]    state;

  logic          disp_en;
  int            errors;
  int            checks;
  int            cyc;
  logic [12:0]   exp_q[$];

  typedef struct packed {
    logic [2:0]  req;
    logic [5:0]  msg;
    logic [29:0] tim;
    logic [2:0]  exp_done;
    logic [2:0]  exp_flags;
    logic [9:0]  exp_time;
  } vec_t;

  vec_t vecs [7];

  lcd_update_arbiter #(.N(N), .HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_req           (req),
    .i_req_msg       (req_msg),
    .i_req_time      (req_time),
    .o_done          (done),
    .o_busy          (busy),
    .o_lcd_update    (upd),
    .i_lcd_ack       (ack),
    .o_cheat         (cheat),
    .o_slow          (slow),
    .o_wait          (wait_f),
    .o_reaction_time (rtime),
    .o_err           (err),
    .o_state         (state)
  );

  // clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] mk(input logic [1:0] m, input logic [9:0] t);
    return {m == 2'b01, m == 2'b10, m == 2'b11, t};
  endfunction

  task automatic set_slice(input int i, input logic [1:0] m, input logic [9:0] t);
    req_msg[2*i +: 2]   = m;
    req_time[10*i +: 10] = t;
  endtask

  task automatic wait_done(input int limit, output logic [2:0] d);
    d = '0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (done != 3'b000) begin
        d = done;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int limit);
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("wait_idle", busy, 1'b0);
  endtask

  // Display model: acks ACK_DLY cycles after update, releases once update drops.
  initial begin
    int dcnt;
    ack  = 1'b0;
    dcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ack  = 1'b0;
        dcnt = 0;
      end else if (disp_en && upd && !ack) begin
        dcnt++;
        if (dcnt == ACK_DLY) begin
          ack  = 1'b1;
          dcnt = 0;
        end
      end else if (ack && !upd) begin
        ack = 1'b0;
      end
    end
  end

  // Scoreboard: every rising LCDUpdate must carry the oldest expected record,
  // and consecutive updates must be more than HOLDOFF cycles apart.
  initial begin
    logic prev_upd;
    logic have_prev;
    int   last_rise;
    logic [12:0] e;
    prev_upd  = 1'b0;
    have_prev = 1'b0;
    last_rise = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_prev = 1'b0;
        prev_upd  = 1'b0;
      end else begin
        if (upd && !prev_upd) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_pop: update seen with data %0h but nothing expected", {cheat, slow, wait_f, rtime});
          end else begin
            e = exp_q.pop_front();
            chk("sb_data", {cheat, slow, wait_f, rtime}, e);
          end
          if (have_prev) chk("sb_gap", (cyc - last_rise) > HOLDOFF, 1'b1);
          last_rise = cyc;
          have_prev = 1'b1;
        end
        prev_upd = upd;
      end
    end
  end

  initial begin
    logic [2:0] d;
    logic       all_busy;
    logic       seen_done;
    int         k;

    vecs[0] = '{3'b010, {2'b00, 2'b01, 2'b00}, {10'd0,    10'd500, 10'd0}, 3'b010, 3'b100, 10'd500};
    vecs[1] = '{3'b010, {2'b00, 2'b11, 2'b00}, {10'd0,    10'd123, 10'd0}, 3'b010, 3'b001, 10'd123};
    vecs[2] = '{3'b100, {2'b10, 2'b00, 2'b00}, {10'd1023, 10'd0,   10'd0}, 3'b100, 3'b010, 10'd1023};
    vecs[3] = '{3'b011, {2'b00, 2'b01, 2'b11}, {10'd0,    10'd7,   10'd0}, 3'b001, 3'b001, 10'd0};
    vecs[4] = '{3'b101, {2'b00, 2'b00, 2'b01}, {10'd777,  10'd0,   10'd9}, 3'b100, 3'b000, 10'd777};
    vecs[5] = '{3'b110, {2'b11, 2'b10, 2'b00}, {10'd1,    10'd256, 10'd0}, 3'b010, 3'b010, 10'd256};
    vecs[6] = '{3'b001, {2'b00, 2'b00, 2'b00}, {10'd0,    10'd0,   10'd1}, 3'b001, 3'b000, 10'd1};

    errors   = 0;
    checks   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    req      = '0;
    req_msg  = '0;
    req_time = '0;
    disp_en  = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_upd",   upd, 1'b0);
    chk("rst_done",  done, 3'b000);
    chk("rst_err",   err, 1'b0);
    chk("rst_flags", {cheat, slow, wait_f}, 3'b000);
    chk("rst_time",  rtime, 10'd0);
    chk("rst_state", state, 3'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single request, cycle-level handshake timing
    set_slice(0, 2'b00, 10'd347);
    exp_q.push_back(mk(2'b00, 10'd347));
    req = 3'b001;
    @(negedge clk);
    chk("s1_grant_upd",   upd, 1'b1);
    chk("s1_grant_time",  rtime, 10'd347);
    chk("s1_grant_flags", {cheat, slow, wait_f}, 3'b000);
    chk("s1_grant_busy",  busy, 1'b1);
    for (k = 0; k < 20; k++) begin
      if (ack) break;
      @(negedge clk);
    end
    chk("s1_ack_seen", ack, 1'b1);
    repeat (ACK_LAT) @(negedge clk);
    @(negedge clk);
    chk("s1_upd_drop", upd, 1'b0);
    chk("s1_ack_fall", ack, 1'b0);
    repeat (ACK_LAT) @(negedge clk);
    chk("s1_done_early", done, 3'b000);
    @(negedge clk);
    chk("s1_done", done, 3'b001);
    @(negedge clk);
    chk("s1_done_one", done, 3'b000);
    chk("s1_hold_busy", busy, 1'b1);
    req = '0;
    all_busy = 1'b1;
    for (int j = 0; j < HOLDOFF - 1; j++) begin
      @(negedge clk);
      if (!busy) all_busy = 1'b0;
    end
    chk("s1_holdoff_busy", all_busy, 1'b1);
    @(negedge clk);
    chk("s1_holdoff_end", busy, 1'b0);

    // table-driven grants, pointer chains from one vector to the next
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      req_msg  = vecs[v].msg;
      req_time = vecs[v].tim;
      exp_q.push_back({vecs[v].exp_flags, vecs[v].exp_time});
      req = vecs[v].req;
      wait_done(400, d);
      chk("vec_done", d, vecs[v].exp_done);
      req = '0;
      wait_idle(HOLDOFF + 50);
    end

    // display never acks: watchdog abort, no Done, sticky Err
    @(negedge clk);
    disp_en = 1'b0;
    set_slice(0, 2'b01, 10'd42);
    exp_q.push_back(mk(2'b01, 10'd42));
    req = 3'b001;
    @(negedge clk);
    chk("to_upd", upd, 1'b1);
    k = 0;
    for (int j = 0; j < TIMEOUT + 50; j++) begin
      @(negedge clk);
      k++;
      if (!upd) break;
    end
    chk("to_cycles", k, TIMEOUT);
    chk("to_err", err, 1'b1);
    req = '0;
    seen_done = 1'b0;
    for (int j = 0; j < HOLDOFF + 50; j++) begin
      @(negedge clk);
      if (done != 3'b000) seen_done = 1'b1;
      if (!busy) break;
    end
    chk("to_no_done", seen_done, 1'b0);
    chk("to_idle", busy, 1'b0);
    disp_en = 1'b1;
    set_slice(1, 2'b10, 10'd600);
    exp_q.push_back(mk(2'b10, 10'd600));
    req = 3'b010;
    wait_done(400, d);
    chk("to_next_done", d, 3'b010);
    chk("to_err_sticky", err, 1'b1);
    req = '0;
    wait_idle(HOLDOFF + 50);

    // asynchronous reset in the middle of ASSERT
    @(negedge clk);
    disp_en = 1'b0;
    set_slice(0, 2'b11, 10'd5);
    exp_q.push_back(mk(2'b11, 10'd5));
    req = 3'b001;
    @(negedge clk);
    chk("ar_upd", upd, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_upd_low",  upd, 1'b0);
    chk("ar_busy_low", busy, 1'b0);
    chk("ar_done_low", done, 3'b000);
    chk("ar_err_clr",  err, 1'b0);
    req = 3'b100;
    set_slice(2, 2'b01, 10'd900);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    disp_en = 1'b1;
    exp_q.push_back(mk(2'b01, 10'd900));
    wait_done(400, d);
    chk("ar_first_grant", d, 3'b100);
    req = '0;
    wait_idle(HOLDOFF + 50);

    // all requesters held: strict round-robin 0,1,2,0,1,2
    @(negedge clk);
    set_slice(0, 2'b00, 10'd111);
    set_slice(1, 2'b01, 10'd222);
    set_slice(2, 2'b10, 10'd333);
    for (int j = 0; j < 6; j++) begin
      case (j % 3)
        0: exp_q.push_back(mk(2'b00, 10'd111));
        1: exp_q.push_back(mk(2'b01, 10'd222));
        default: exp_q.push_back(mk(2'b10, 10'd333));
      endcase
    end
    req = 3'b111;
    for (int j = 0; j < 6; j++) begin
      wait_done(HOLDOFF + 100, d);
      chk("rr_order", d, 3'b001 << (j % 3));
    end
    req = '0;
    wait_idle(HOLDOFF + 50);

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
